// File: rtl/demux8_tdm.sv
`default_nettype none
// ============================================================================
//  Module   : demux8_tdm
//  Purpose  : Receive end of an 8-slot TDM serial link. Aligns to the frame
//             marker, assembles slots 0..7 into a word, strobes y_valid.
//             Define DEMUX8_PARITY_EN to add a 9th even-parity slot.
//  Revision : 1.0  initial release
// ============================================================================
module demux8_tdm (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       frame,
   input  logic       d,
   output logic [7:0] y,
   output logic       y_valid,
   output logic [3:0] slot,
   output logic       sync_err,
   output logic       par_err
);

   localparam logic [3:0] c_last_data = 4'd7;
`ifdef DEMUX8_PARITY_EN
   localparam logic [3:0] c_parity_slot = 4'd8;
`endif

   typedef enum logic [0:0] {
      ST_HUNT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_slot;
   logic [3:0] w_slot_nxt;
   logic [7:0] r_shadow;
   logic [7:0] w_shadow_nxt;
   logic [7:0] r_y;
   logic [7:0] w_y_nxt;
   logic       r_y_valid;
   logic       w_y_valid_nxt;
   logic       r_sync_err;
   logic       w_sync_err_nxt;
   logic       r_par_err;
   logic       w_par_err_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_HUNT;
         r_slot     <= 4'd0;
         r_shadow   <= 8'h00;
         r_y        <= 8'h00;
         r_y_valid  <= 1'b0;
         r_sync_err <= 1'b0;
         r_par_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_slot     <= w_slot_nxt;
         r_shadow   <= w_shadow_nxt;
         r_y        <= w_y_nxt;
         r_y_valid  <= w_y_valid_nxt;
         r_sync_err <= w_sync_err_nxt;
         r_par_err  <= w_par_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_slot_nxt     = r_slot;
      w_shadow_nxt   = r_shadow;
      w_y_nxt        = r_y;
      w_y_valid_nxt  = 1'b0;
      w_sync_err_nxt = 1'b0;
      w_par_err_nxt  = 1'b0;

      // Without in_valid everything holds and the pulses simply drop.
      if (in_valid) begin
         case (r_state)
            ST_HUNT: begin
               if (frame) begin
                  w_shadow_nxt[0] = d;
                  w_slot_nxt      = 4'd1;
                  w_state_nxt     = ST_RUN;
               end
            end

            ST_RUN: begin
               if (r_slot == 4'd0) begin
                  if (frame) begin
                     w_shadow_nxt[0] = d;
                     w_slot_nxt      = 4'd1;
                  end else begin
                     w_sync_err_nxt = 1'b1;
                     w_state_nxt    = ST_HUNT;
                  end
               end else if (frame) begin
                  // Early marker: drop the partial word and resync on this beat.
                  w_sync_err_nxt  = 1'b1;
                  w_shadow_nxt[0] = d;
                  w_slot_nxt      = 4'd1;
               end else if (r_slot == c_last_data) begin
                  w_shadow_nxt[7] = d;
`ifdef DEMUX8_PARITY_EN
                  w_slot_nxt      = c_parity_slot;
`else
                  w_y_nxt         = w_shadow_nxt;
                  w_y_valid_nxt   = 1'b1;
                  w_slot_nxt      = 4'd0;
`endif
               end
`ifdef DEMUX8_PARITY_EN
               else if (r_slot == c_parity_slot) begin
                  // Even parity: data bits plus parity bit hold an even count of ones.
                  if (d == ^r_shadow) begin
                     w_y_nxt       = r_shadow;
                     w_y_valid_nxt = 1'b1;
                  end else begin
                     w_par_err_nxt = 1'b1;
                  end
                  w_slot_nxt = 4'd0;
               end
`endif
               else begin
                  w_shadow_nxt[r_slot[2:0]] = d;
                  w_slot_nxt                = r_slot + 4'd1;
               end
            end

            default: begin
               w_state_nxt = ST_HUNT;
               w_slot_nxt  = 4'd0;
            end
         endcase
      end
   end

   assign y        = r_y;
   assign y_valid  = r_y_valid;
   assign slot     = r_slot;
   assign sync_err = r_sync_err;
   assign par_err  = r_par_err;

endmodule
`default_nettype wire

// File: tb/tb_demux8_tdm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux8_tdm
//  Purpose  : Directed self-checking bench for demux8_tdm (DEMUX8_PARITY_EN
//             adds the parity slot and parity scenarios).
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux8_tdm;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       frame;
   logic       d;
   logic [7:0] y;
   logic       y_valid;
   logic [3:0] slot;
   logic       sync_err;
   logic       par_err;

   int checks = 0;
   int errors = 0;

`ifdef DEMUX8_PARITY_EN
   localparam int FRAME_LEN = 9;
`else
   localparam int FRAME_LEN = 8;
`endif

   demux8_tdm dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .frame    (frame),
      .d        (d),
      .y        (y),
      .y_valid  (y_valid),
      .slot     (slot),
      .sync_err (sync_err),
      .par_err  (par_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic f, input logic b);
      in_valid = 1'b1;
      frame    = f;
      d        = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      frame    = 1'b0;
      d        = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends slots first..7 of w (frame on slot 0) plus the parity slot if built in.
   task automatic send_from(input logic [7:0] w, input int first);
      for (int k = first; k < 8; k++) beat(k == 0, w[k]);
`ifdef DEMUX8_PARITY_EN
      beat(1'b0, ^w);
`endif
   endtask

   initial begin
      logic [7:0] w;
      int         stray;
      reset    = 1'b1;
      in_valid = 1'b0;
      frame    = 1'b0;
      d        = 1'b0;

      // Reset state
      #2;
      chk("rst_y", y, 8'h00);
      chk("rst_yv", {7'd0, y_valid}, 8'd0);
      chk("rst_slot", {4'd0, slot}, 8'd0);
      chk("rst_err", {6'd0, sync_err, par_err}, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Frame 0x65 with continuous valid
      w = 8'h65;
      beat(1'b1, w[0]);
      chk("t1_slot1", {4'd0, slot}, 8'd1);
      send_from(w, 1);
      chk("t1_y", y, 8'h65);
      chk("t1_yv", {7'd0, y_valid}, 8'd1);
      chk("t1_slot0", {4'd0, slot}, 8'd0);
      idle(1);
      chk("t1_yv_drop", {7'd0, y_valid}, 8'd0);
      chk("t1_y_hold", y, 8'h65);

      // Same frame with 3 stall cycles after slot 3
      for (int k = 0; k < 4; k++) beat(k == 0, w[k]);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("t2_stall_slot", {4'd0, slot}, 8'd4);
         chk("t2_stall_yv", {7'd0, y_valid}, 8'd0);
      end
      send_from(w, 4);
      chk("t2_y", y, 8'h65);
      chk("t2_yv", {7'd0, y_valid}, 8'd1);

      // Frame marker re-asserted at slot 5 starts a new word 0x0F
      w = 8'h0F;
      for (int k = 0; k < 5; k++) beat(k == 0, 1'b1);
      chk("t3_slot5", {4'd0, slot}, 8'd5);
      beat(1'b1, w[0]);
      chk("t3_sync", {7'd0, sync_err}, 8'd1);
      chk("t3_no_yv", {7'd0, y_valid}, 8'd0);
      chk("t3_slot1", {4'd0, slot}, 8'd1);
      beat(1'b0, w[1]);
      chk("t3_sync_drop", {7'd0, sync_err}, 8'd0);
      send_from(w, 2);
      chk("t3_y", y, 8'h0F);
      chk("t3_yv", {7'd0, y_valid}, 8'd1);
      chk("t3_no_sync", {7'd0, sync_err}, 8'd0);

      // Back-to-back frames 0xA5, 0x3C
      send_from(8'hA5, 0);
      chk("t4_y0", y, 8'hA5);
      chk("t4_yv0", {7'd0, y_valid}, 8'd1);
      stray = 0;
      w = 8'h3C;
      for (int k = 0; k < 8; k++) begin
         beat(k == 0, w[k]);
         if (k < 7 && y_valid) stray++;
      end
`ifdef DEMUX8_PARITY_EN
      if (y_valid) stray++;
      beat(1'b0, ^w);
`endif
      chk("t4_gap", stray[7:0], 8'd0);
      chk("t4_y1", y, 8'h3C);
      chk("t4_yv1", {7'd0, y_valid}, 8'd1);

      // Missing frame marker at slot 0 drops to hunting
      beat(1'b0, 1'b1);
      chk("t5_sync", {7'd0, sync_err}, 8'd1);
      beat(1'b0, 1'b1);
      chk("t5_hunt", {6'd0, sync_err, y_valid}, 8'd0);
      chk("t5_hunt_slot", {4'd0, slot}, 8'd0);

      // Asynchronous reset at slot 4
      for (int k = 0; k < 4; k++) beat(k == 0, 1'b1);
      chk("t6_slot4", {4'd0, slot}, 8'd4);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_y", y, 8'h00);
      chk("t6_rst_slot", {4'd0, slot}, 8'd0);
      chk("t6_rst_yv", {7'd0, y_valid}, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) beat(1'b0, 1'b1);
      chk("t6_ignored", {3'd0, slot, y_valid}, 8'd0);
      send_from(8'h5A, 0);
      chk("t6_y", y, 8'h5A);
      chk("t6_yv", {7'd0, y_valid}, 8'd1);

`ifdef DEMUX8_PARITY_EN
      // Parity good then parity bad
      for (int k = 0; k < 8; k++) beat(k == 0, w[k] & 1'b0 | (k < 3));
      beat(1'b0, 1'b1);
      chk("p_y", y, 8'h07);
      chk("p_yv", {7'd0, y_valid}, 8'd1);
      chk("p_no_perr", {7'd0, par_err}, 8'd0);
      w = 8'h81;
      for (int k = 0; k < 8; k++) beat(k == 0, w[k]);
      beat(1'b0, 1'b1);
      chk("p_perr", {7'd0, par_err}, 8'd1);
      chk("p_bad_yv", {7'd0, y_valid}, 8'd0);
      chk("p_y_hold", y, 8'h07);
      chk("p_slot0", {4'd0, slot}, 8'd0);
`else
      chk("no_perr", {7'd0, par_err}, 8'd0);
`endif

      chk("frame_len", FRAME_LEN[7:0], (FRAME_LEN == 9) ? 8'd9 : 8'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
